// File: rtl/pe_noc_adapter_if.sv
// pe_noc_adapter_if: PE request, router packet and PE delivery handshakes for pe_noc_adapter
interface pe_noc_adapter_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_dest;
  logic [1:0]  tx_type;
  logic [39:0] tx_payload;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [56:0] pkt_out_data;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [56:0] pkt_in_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  rx_src;
  logic [1:0]  rx_type;
  logic [6:0]  rx_seq;
  logic [39:0] rx_payload;
  logic [7:0]  drop_cnt;
  modport master (
    input  tx_valid, tx_dest, tx_type, tx_payload, pkt_out_ready, pkt_in_valid, pkt_in_data, rx_ready,
    output tx_ready, pkt_out_valid, pkt_out_data, pkt_in_ready, rx_valid, rx_src, rx_type, rx_seq,
           rx_payload, drop_cnt
  );
  modport slave (
    output tx_valid, tx_dest, tx_type, tx_payload, pkt_out_ready, pkt_in_valid, pkt_in_data, rx_ready,
    input  tx_ready, pkt_out_valid, pkt_out_data, pkt_in_ready, rx_valid, rx_src, rx_type, rx_seq,
           rx_payload, drop_cnt
  );
endinterface

// File: rtl/pe_noc_adapter.sv
// pe_noc_adapter: PE <-> mesh local-port adapter with seq-stamping TX FIFO and dest-filtering RX FIFO
module pe_noc_adapter #(
  parameter logic [3:0] NODE_ID      = 4'd1,
  parameter int         WIDTH_packet = 57,
  parameter int         DEPTH        = 4
) (
  input logic              clk,
  input logic              rst,
  pe_noc_adapter_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = WIDTH_packet - 4;
  logic [WIDTH_packet-1:0] tx_mem_q [DEPTH];
  logic [RW-1:0]           rx_mem_q [DEPTH];
  logic [AW-1:0] tx_rp_q, tx_rp_d, tx_wp_q, tx_wp_d, rx_rp_q, rx_rp_d, rx_wp_q, rx_wp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [6:0]    seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;
  logic [8:0]    drop_sum;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_acc, tx_push, tx_pop, rx_acc, rx_push, rx_pop;
  logic [WIDTH_packet-1:0] tx_pkt;
  logic [RW-1:0]           rx_head;
  always_comb begin
    tx_empty = tx_cnt_q == '0;
    tx_full  = tx_cnt_q == CW'(DEPTH);
    rx_empty = rx_cnt_q == '0;
    rx_full  = rx_cnt_q == CW'(DEPTH);
    tx_acc   = bus.tx_valid && !tx_full;
    tx_push  = tx_acc && bus.tx_dest != 4'd0;
    tx_pop   = !tx_empty && bus.pkt_out_ready;
    rx_acc   = bus.pkt_in_valid && !rx_full;
    rx_push  = rx_acc && bus.pkt_in_data[56:53] == NODE_ID;
    rx_pop   = !rx_empty && bus.rx_ready;
    tx_pkt   = {bus.tx_dest, NODE_ID, bus.tx_type, seq_q, bus.tx_payload};
    tx_wp_d  = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop ? tx_rp_q + AW'(1) : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop ? rx_rp_q + AW'(1) : rx_rp_q;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    seq_d    = tx_push ? seq_q + 7'd1 : seq_q;
    drop_sum = {1'b0, drop_q} + 9'(tx_acc && !tx_push) + 9'(rx_acc && !rx_push);
    drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];
    rx_head  = rx_empty ? '0 : rx_mem_q[rx_rp_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rp_q  <= '0;
      tx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_wp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      tx_rp_q  <= tx_rp_d;
      tx_wp_q  <= tx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_wp_q  <= rx_wp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= tx_pkt;
    if (rx_push) rx_mem_q[rx_wp_q] <= bus.pkt_in_data[RW-1:0];
  end
  assign bus.tx_ready      = !tx_full;
  assign bus.pkt_out_valid = !tx_empty;
  assign bus.pkt_out_data  = tx_empty ? '0 : tx_mem_q[tx_rp_q];
  assign bus.pkt_in_ready  = !rx_full;
  assign bus.rx_valid      = !rx_empty;
  assign bus.rx_src        = rx_head[52:49];
  assign bus.rx_type       = rx_head[48:47];
  assign bus.rx_seq        = rx_head[46:40];
  assign bus.rx_payload    = rx_head[39:0];
  assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_pe_noc_adapter.sv
// tb_pe_noc_adapter: randomized scoreboard bench for pe_noc_adapter at NODE_ID=3, DEPTH=4
module tb_pe_noc_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pe_noc_adapter_if bus();
  pe_noc_adapter #(.NODE_ID(4'd3), .WIDTH_packet(57), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [56:0] tx_exp[$];
  logic [52:0] rx_exp[$];
  int model_seq = 0;
  int model_drop = 0;
  bit rand_done = 1'b0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] sat_drop();
    return 64'(model_drop > 255 ? 255 : model_drop);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_tx(logic [3:0] dest, logic [1:0] typ, logic [39:0] pay);
    int t = 0;
    bus.tx_dest = dest;
    bus.tx_type = typ;
    bus.tx_payload = pay;
    bus.tx_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        if (dest != 4'd0) begin
          tx_exp.push_back({dest, 4'd3, typ, 7'(model_seq), pay});
          model_seq = (model_seq + 1) % 128;
        end else model_drop++;
        break;
      end
      t++;
      if (t > 1000) begin
        check("tx_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    step();
    bus.tx_valid = 1'b0;
  endtask
  task automatic send_pkt(logic [56:0] data);
    int t = 0;
    bus.pkt_in_data = data;
    bus.pkt_in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.pkt_in_ready) begin
        if (data[56:53] == 4'd3) rx_exp.push_back(data[52:0]);
        else model_drop++;
        break;
      end
      t++;
      if (t > 1000) begin
        check("rx_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    step();
    bus.pkt_in_valid = 1'b0;
  endtask
  function automatic logic [56:0] rand_pkt(logic [3:0] dest);
    return {dest, 4'($urandom), 2'($urandom), 7'($urandom), 8'($urandom), 32'($urandom)};
  endfunction
  function automatic logic [56:0] mismatch_pkt();
    logic [3:0] d = 4'((3 + $urandom_range(1, 15)) % 16);
    return rand_pkt(d);
  endfunction
  task automatic check_idle(string tag);
    check({tag, "_tx_ready"}, 64'(bus.tx_ready), 64'd1);
    check({tag, "_pkt_in_ready"}, 64'(bus.pkt_in_ready), 64'd1);
    check({tag, "_pkt_out_valid"}, 64'(bus.pkt_out_valid), 64'd0);
    check({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'd0);
    check({tag, "_pkt_out_data"}, 64'(bus.pkt_out_data), 64'd0);
    check({tag, "_rx_fields"}, 64'({bus.rx_src, bus.rx_type, bus.rx_seq, bus.rx_payload}), 64'd0);
    check({tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'd0);
  endtask
  task automatic pulse_reset(string tag);
    rst = 1'b1;
    tx_exp.delete();
    rx_exp.delete();
    model_seq = 0;
    model_drop = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_idle(tag);
    step();
  endtask
  task automatic wait_drain(string tag);
    int t = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    check({tag, "_drained"}, 64'(tx_exp.size() + rx_exp.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.pkt_out_valid && bus.pkt_out_ready) begin
      if (tx_exp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got %h expected no packet", bus.pkt_out_data);
      end else check("tx_pkt", 64'(bus.pkt_out_data), 64'(tx_exp.pop_front()));
    end
    if (!rst && bus.rx_valid && bus.rx_ready) begin
      if (rx_exp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got %h expected no delivery",
                 {bus.rx_src, bus.rx_type, bus.rx_seq, bus.rx_payload});
      end else check("rx_deliver", 64'({bus.rx_src, bus.rx_type, bus.rx_seq, bus.rx_payload}),
                     64'(rx_exp.pop_front()));
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_dest = '0;
    bus.tx_type = '0;
    bus.tx_payload = '0;
    bus.pkt_out_ready = 1'b1;
    bus.pkt_in_valid = 1'b0;
    bus.pkt_in_data = '0;
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    step();
    rst = 1'b0;
    step();
    send_tx(4'd7, 2'd2, 40'h12_3456_789A);
    @(negedge clk);
    check("tx_basic_valid", 64'(bus.pkt_out_valid), 64'd1);
    check("tx_basic_data", 64'(bus.pkt_out_data), 64'({4'd7, 4'd3, 2'd2, 7'd0, 40'h12_3456_789A}));
    step();
    send_tx(4'd1, 2'd0, 40'($urandom));
    @(negedge clk);
    check("tx_seq1", 64'(bus.pkt_out_data[46:40]), 64'd1);
    step();
    bus.pkt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_tx(4'($urandom_range(1, 15)), 2'($urandom), {8'($urandom), 32'($urandom)});
    bus.tx_dest = 4'd9;
    bus.tx_type = 2'd3;
    bus.tx_payload = 40'hAB_CDEF_0123;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_ready_full", 64'(bus.tx_ready), 64'd0);
      step();
    end
    bus.pkt_out_ready = 1'b1;
    send_tx(4'd9, 2'd3, 40'hAB_CDEF_0123);
    wait_drain("backpressure");
    pulse_reset("rst_wrap");
    for (int i = 0; i < 130; i++) send_tx(4'($urandom_range(1, 15)), 2'($urandom), {8'($urandom), 32'($urandom)});
    wait_drain("seq_wrap");
    pulse_reset("rst_filter");
    send_pkt({4'd3, 4'd5, 2'd1, 7'd9, 40'h00_1122_3344});
    send_pkt({4'd5, 4'd6, 2'd0, 7'd2, 40'h55_6677_8899});
    wait_drain("rx_filter");
    @(negedge clk);
    check("rx_filter_drop", 64'(bus.drop_cnt), 64'd1);
    step();
    send_tx(4'd0, 2'd1, 40'h1);
    @(negedge clk);
    check("tx_dest0_drop", 64'(bus.drop_cnt), 64'd2);
    check("tx_dest0_no_pkt", 64'(bus.pkt_out_valid), 64'd0);
    step();
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pkt(rand_pkt(4'd3));
    @(negedge clk);
    check("rx_full_ready", 64'(bus.pkt_in_ready), 64'd0);
    check("rx_full_valid", 64'(bus.rx_valid), 64'd1);
    step();
    bus.rx_ready = 1'b1;
    wait_drain("rx_full");
    for (int i = 0; i < 300; i++) send_pkt(mismatch_pkt());
    @(negedge clk);
    check("drop_sat", 64'(bus.drop_cnt), 64'd255);
    check("drop_model", 64'(bus.drop_cnt), sat_drop());
    step();
    bus.pkt_out_ready = 1'b0;
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_tx(4'($urandom_range(1, 15)), 2'($urandom), {8'($urandom), 32'($urandom)});
      send_pkt(rand_pkt(4'd3));
    end
    @(negedge clk);
    check("pre_reset_valids", 64'({bus.pkt_out_valid, bus.rx_valid}), 64'd3);
    step();
    pulse_reset("rst_mid");
    bus.pkt_out_ready = 1'b1;
    bus.rx_ready = 1'b1;
    send_tx(4'd12, 2'd1, 40'hFE_DCBA_9876);
    @(negedge clk);
    check("post_reset_seq", 64'(bus.pkt_out_data[46:40]), 64'd0);
    step();
    wait_drain("post_reset");
    pulse_reset("rst_rand");
    rand_done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 150; i++) begin
            send_tx(4'($urandom_range(0, 15)), 2'($urandom), {8'($urandom), 32'($urandom)});
            repeat ($urandom_range(0, 2)) step();
          end
          for (int i = 0; i < 150; i++) begin
            send_pkt($urandom_range(0, 1) != 0 ? rand_pkt(4'd3) : rand_pkt(4'($urandom)));
            repeat ($urandom_range(0, 2)) step();
          end
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        bus.pkt_out_ready = $urandom_range(0, 3) != 0;
        bus.rx_ready = $urandom_range(0, 3) != 0;
        step();
      end
    join
    bus.pkt_out_ready = 1'b1;
    bus.rx_ready = 1'b1;
    wait_drain("random");
    @(negedge clk);
    check("random_drop", 64'(bus.drop_cnt), sat_drop());
    check("random_idle", 64'({bus.pkt_out_valid, bus.rx_valid}), 64'd0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
